// File: rtl/usart_seq_pkg.sv
// Shared types and default sizing for the USART transmit sequencer.
package usart_seq_pkg;

  localparam int DEF_DEPTH       = 64;
  localparam int DEF_AW          = 6;
  localparam int DEF_GAP_W       = 16;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    END,
    GAP
  } seq_state_e;

endpackage

// File: rtl/usart_msg_buf.sv
// Message RAM: one synchronous write port, one registered read port whose
// output register doubles as the byte presented to the USART.
module usart_msg_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // Storage is never reset so a message survives a sequencer reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read register only loads on rd_en, so later writes to the same
  // address cannot disturb a byte already latched for transmission.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/usart_tx_sequencer.sv
// Streams a stored message byte by byte into my_usart over a start/ready
// handshake, with optional repetition separated by a programmable gap.
module usart_tx_sequencer
  import usart_seq_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AW          = DEF_AW,
  parameter int GAP_W       = DEF_GAP_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [AW:0]      msg_len,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_en,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    byte_idx
);

  localparam int LW    = AW + 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  seq_state_e       state_q;
  logic [AW:0]      len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [ACK_W-1:0] ack_cnt_q;
  logic [AW-1:0]    byte_idx_q;
  logic             stop_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             stop_eff;
  logic             last_byte;
  logic             rd_en;

  assign stop_eff  = stop_q | stop;
  assign last_byte = ({1'b0, byte_idx_q} == (len_q - LW'(1)));
  assign rd_en     = (state_q == LOAD);

  usart_msg_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (byte_idx_q),
    .rd_data (tx_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      byte_idx_q <= '0;
      stop_q     <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (state_q != IDLE && stop) stop_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // Clearing here also drops a stop raised alongside an accepted start.
          stop_q <= 1'b0;
          if (start) begin
            if (msg_len != '0) begin
              len_q      <= msg_len;
              gap_q      <= gap_cycles;
              byte_idx_q <= '0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        LOAD: state_q <= SEND;

        SEND: begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            ack_cnt_q  <= '0;
            state_q    <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (!tx_ready) begin
            state_q <= WAIT_DONE;
          end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
          end
        end

        WAIT_DONE: begin
          if (tx_ready) begin
            if (stop_eff) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (last_byte) begin
              state_q <= END;
            end else begin
              byte_idx_q <= byte_idx_q + AW'(1);
              state_q    <= LOAD;
            end
          end
        end

        END: begin
          if (stop_eff || !repeat_en) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (gap_q != '0) begin
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else begin
            byte_idx_q <= '0;
            state_q    <= LOAD;
          end
        end

        GAP: begin
          if (stop_eff) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (gap_cnt_q == (gap_q - GAP_W'(1))) begin
            byte_idx_q <= '0;
            state_q    <= LOAD;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign byte_idx = byte_idx_q;

endmodule

// File: doc/usart_tx_sequencer.md
Name: usart_tx_sequencer

Overview:
- Stores a message of up to DEPTH bytes and streams it, byte by byte, into the my_usart transmitter using a start/ready handshake.
- Optionally repeats the message after a programmable gap.
- Sits between host/test logic and my_usart, replacing ad-hoc per-byte transmit toggling in top-level testers.

Parameters:
- DEPTH, 64, message buffer size in bytes (power of 2).
- AW, 6, buffer address width; equals log2(DEPTH).
- GAP_W, 16, width of the inter-message gap counter.
- ACK_TIMEOUT, 255, max cycles to wait for the USART to drop tx_ready after tx_start.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  buffer write byte.
- msg_len  in  AW+1  bytes to send, 0..DEPTH; sampled on start.
- start  in  1  begin transmission (level-sampled while IDLE).
- stop  in  1  abort after the current byte completes.
- repeat_en  in  1  resend after the gap; sampled at end of each message.
- gap_cycles  in  GAP_W  idle cycles between repeats; sampled on start.
- tx_ready  in  1  from USART: high = idle and able to accept a byte.
- tx_data  out  8  byte to USART.
- tx_start  out  1  one-cycle request pulse to USART.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a message finishes or a stop completes.
- err  out  1  sticky ACK timeout flag; cleared by the next accepted start.
- byte_idx  out  AW  index of the byte in flight.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. tx_data=0, tx_start=0, busy=0, done=0, err=0, byte_idx=0. Buffer contents are not cleared.
- Buffer: synchronous write on clock when wr_en=1, in any state. A write to the byte currently in flight does not alter the latched tx_data.
- IDLE:
  - start=1 and msg_len≠0: latch len and gap, byte_idx=0, clear err, go to LOAD.
  - start=1 and msg_len=0: pulse done next cycle and stay in IDLE.
- LOAD: read buf[byte_idx] into tx_data (1 cycle, registered read). Go to SEND.
- SEND: wait for tx_ready=1. When seen, assert tx_start for exactly one cycle and go to WAIT_ACK. tx_data holds until the state leaves WAIT_DONE.
- WAIT_ACK:
  - tx_ready=0 → go to WAIT_DONE.
  - No fall within ACK_TIMEOUT cycles → set err, pulse done, go to IDLE.
- WAIT_DONE: wait for tx_ready=1, then:
  - stop seen during this byte → done pulse, go to IDLE.
  - else byte_idx=len-1 → END.
  - else byte_idx+1 → LOAD.
- END:
  - repeat_en=1 and gap≠0 → GAP.
  - repeat_en=1 and gap=0 → byte_idx=0, go to LOAD.
  - else pulse done, go to IDLE.
- GAP: count gap cycles, then byte_idx=0 and go to LOAD. stop during GAP → done pulse, go to IDLE.
- stop handling:
  - Latched when asserted in any non-IDLE state; acted on at the next byte boundary or during GAP.
  - stop in IDLE is ignored.
  - start and stop both high in IDLE → start wins; the stop is not latched.
- Repeat path: done pulses only when the sequence ends, not once per repetition.
- byte_idx arithmetic is AW bits wide. len=DEPTH is legal; the last index is DEPTH-1 and there is no wrap beyond it.
- Latency: start to first tx_start = 3 cycles when tx_ready is already high (IDLE→LOAD→SEND, pulse in the SEND cycle).
- Reset mid-byte: immediate return to IDLE. The USART may still finish the current frame; that is acceptable.

Decomposition:
- Package usart_seq_pkg:
  - state enum: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, END, GAP.
  - default DEPTH and GAP_W constants.
- Sub-module usart_msg_buf: DEPTH×8 RAM with one synchronous write port and one registered read port.

Test Plan:
- Write "HELLO" to addresses 0-4, msg_len=5, start pulse, USART model with 10-cycle frames → tx_start pulses carry 0x48,0x45,0x4C,0x4C,0x4F in order; one done pulse; busy falls with done.
- msg_len=0, start → done pulse 1 cycle later; tx_start never asserts; busy stays 0.
- repeat_en=1, gap_cycles=20, msg_len=2 → after the 2nd byte, ≥20 cycles with no tx_start, then byte 0 again. Deassert repeat_en → done after that message ends.
- Model holds tx_ready=1 forever after the first tx_start → err=1 and done pulse after 255 cycles; state returns to IDLE; next start clears err.
- stop asserted during byte 2 of 5 → byte 2 completes, no byte 3, done pulse.
- Assert reset mid-WAIT_DONE → all outputs 0 immediately (asynchronous); subsequent start replays from byte 0.
